// File: rtl/hicore_icb_arbt.sv
// Two-master ICB arbiter (LSU = m0, IFU = m1) onto one slave port, with
// round-robin grant and an in-order ID FIFO that steers responses back.
module hicore_icb_arbt #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic            m0_icb_cmd_read,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,

  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic            m1_icb_cmd_read,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,

  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic            o_icb_cmd_read,
  output logic [AW-1:0]   o_icb_cmd_addr,
  output logic [DW-1:0]   o_icb_cmd_wdata,
  output logic [DW/8-1:0] o_icb_cmd_wmask,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic            o_icb_rsp_err,
  input  logic [DW-1:0]   o_icb_rsp_rdata
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both 1; a sender keeps valid and its fields
  // stable until that edge, and ready may depend combinationally on valid.

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTS_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTS_DEPTH - 1);

  logic [OUTS_DEPTH-1:0] id_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  last_grant;
  logic                  hold;
  logic                  held_id;
  logic                  grant;
  logic                  grant_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head;
  logic                  cmd_hs;
  logic                  rsp_hs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head       = id_mem[rd_ptr];

  // A stalled command pins the grant so the slave never sees it change.
  always_comb begin
    grant = 1'b0;
    if (hold)
      grant = held_id;
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid)
      grant = ~last_grant;
    else
      grant = m1_icb_cmd_valid;
  end

  assign grant_valid = grant ? m1_icb_cmd_valid : m0_icb_cmd_valid;

  // Full blocks the command even if a pop lands this cycle, keeping the
  // command path free of response-path timing.
  assign o_icb_cmd_valid  = grant_valid & ~fifo_full & ~rst;
  assign o_icb_cmd_read   = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign o_icb_cmd_addr   = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign o_icb_cmd_wdata  = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign o_icb_cmd_wmask  = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  assign m0_icb_cmd_ready = ~grant & o_icb_cmd_ready & ~fifo_full & ~rst;
  assign m1_icb_cmd_ready =  grant & o_icb_cmd_ready & ~fifo_full & ~rst;

  assign m0_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty & ~head & ~rst;
  assign m1_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty &  head & ~rst;
  assign o_icb_rsp_ready  = (head ? m1_icb_rsp_ready : m0_icb_rsp_ready)
                            & ~fifo_empty & ~rst;
  assign m0_icb_rsp_err   = o_icb_rsp_err;
  assign m1_icb_rsp_err   = o_icb_rsp_err;
  assign m0_icb_rsp_rdata = o_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = o_icb_rsp_rdata;

  assign cmd_hs = o_icb_cmd_valid & o_icb_cmd_ready;
  assign rsp_hs = o_icb_rsp_valid & o_icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      hold       <= 1'b0;
      held_id    <= 1'b0;
    end else begin
      if (cmd_hs) begin
        wr_ptr     <= ptr_inc(wr_ptr);
        last_grant <= grant;
        hold       <= 1'b0;
      end else if (o_icb_cmd_valid) begin
        hold    <= 1'b1;
        held_id <= grant;
      end
      if (rsp_hs)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({cmd_hs, rsp_hs})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read below count.
  always_ff @(posedge clk) begin
    if (cmd_hs)
      id_mem[wr_ptr] <= grant;
  end

`ifndef SYNTHESIS
  rsp_while_empty: assert property (@(posedge clk) disable iff (rst)
    !(o_icb_rsp_valid && fifo_empty))
    else $error("hicore_icb_arbt: response with no outstanding command");
`endif

endmodule

// File: tb/tb_hicore_icb_arbt.sv
// Bench for hicore_icb_arbt: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of outstanding commands.
module tb_hicore_icb_arbt;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [AW-1:0] m0_icb_cmd_addr;
  logic [DW-1:0] m0_icb_cmd_wdata;
  logic [MW-1:0] m0_icb_cmd_wmask;
  logic m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [DW-1:0] m0_icb_rsp_rdata;
  logic m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [AW-1:0] m1_icb_cmd_addr;
  logic [DW-1:0] m1_icb_cmd_wdata;
  logic [MW-1:0] m1_icb_cmd_wmask;
  logic m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [DW-1:0] m1_icb_rsp_rdata;
  logic o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
  logic [AW-1:0] o_icb_cmd_addr;
  logic [DW-1:0] o_icb_cmd_wdata;
  logic [MW-1:0] o_icb_cmd_wmask;
  logic o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err;
  logic [DW-1:0] o_icb_rsp_rdata;

  hicore_icb_arbt #(.AW(AW), .DW(DW), .OUTS_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
    .o_icb_cmd_read(o_icb_cmd_read), .o_icb_cmd_addr(o_icb_cmd_addr),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
    .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_rdata(o_icb_rsp_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding master ids in issue order, last winner,
  // and the master whose stalled command must keep the grant (-1 if none).
  logic [0:0] exp_q[$];
  int         last_m  = 1;
  int         lock_id = -1;
  int         grant_log[$];
  bit         acc0, acc1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = rd; m0_icb_cmd_addr = a;
    m0_icb_cmd_wdata = wd; m0_icb_cmd_wmask = wm;
  endtask

  task automatic set_m1(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    m1_icb_cmd_valid = 1'b1; m1_icb_cmd_read = rd; m1_icb_cmd_addr = a;
    m1_icb_cmd_wdata = wd; m1_icb_cmd_wmask = wm;
  endtask

  // One clock: check all outputs against the model, cross the edge, update.
  task automatic cycle();
    int g;
    bit ecv, hs, ne, ers, pop, full;
    logic hd;
    #3;
    acc0 = 0; acc1 = 0;
    if (rst) begin
      chk("rst_cmd_valid", 64'(o_icb_cmd_valid), 64'(0));
      chk("rst_m0_cmd_ready", 64'(m0_icb_cmd_ready), 64'(0));
      chk("rst_m1_cmd_ready", 64'(m1_icb_cmd_ready), 64'(0));
      chk("rst_m0_rsp_valid", 64'(m0_icb_rsp_valid), 64'(0));
      chk("rst_m1_rsp_valid", 64'(m1_icb_rsp_valid), 64'(0));
      chk("rst_rsp_ready", 64'(o_icb_rsp_ready), 64'(0));
      @(posedge clk);
      exp_q.delete(); last_m = 1; lock_id = -1;
      #1;
      return;
    end
    if (lock_id >= 0) g = lock_id;
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid) g = (last_m == 1) ? 0 : 1;
    else g = m1_icb_cmd_valid ? 1 : 0;
    full = (exp_q.size() >= D);
    ecv  = ((g == 0) ? m0_icb_cmd_valid : m1_icb_cmd_valid) && !full;
    chk("cmd_valid", 64'(o_icb_cmd_valid), 64'(ecv));
    if (ecv) begin
      chk("cmd_addr", 64'(o_icb_cmd_addr), 64'((g == 0) ? m0_icb_cmd_addr : m1_icb_cmd_addr));
      chk("cmd_read", 64'(o_icb_cmd_read), 64'((g == 0) ? m0_icb_cmd_read : m1_icb_cmd_read));
      chk("cmd_wdata", 64'(o_icb_cmd_wdata), 64'((g == 0) ? m0_icb_cmd_wdata : m1_icb_cmd_wdata));
      chk("cmd_wmask", 64'(o_icb_cmd_wmask), 64'((g == 0) ? m0_icb_cmd_wmask : m1_icb_cmd_wmask));
    end
    if (m0_icb_cmd_valid)
      chk("m0_cmd_ready", 64'(m0_icb_cmd_ready), 64'(g == 0 && o_icb_cmd_ready && !full));
    if (m1_icb_cmd_valid)
      chk("m1_cmd_ready", 64'(m1_icb_cmd_ready), 64'(g == 1 && o_icb_cmd_ready && !full));
    hs = ecv && o_icb_cmd_ready;
    ne = (exp_q.size() > 0);
    hd = ne ? exp_q[0] : 1'b0;
    chk("m0_rsp_valid", 64'(m0_icb_rsp_valid), 64'(o_icb_rsp_valid && ne && hd == 1'b0));
    chk("m1_rsp_valid", 64'(m1_icb_rsp_valid), 64'(o_icb_rsp_valid && ne && hd == 1'b1));
    ers = ne && (hd ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    chk("rsp_ready", 64'(o_icb_rsp_ready), 64'(ers));
    if (o_icb_rsp_valid && ne) begin
      chk("rsp_rdata", 64'(hd ? m1_icb_rsp_rdata : m0_icb_rsp_rdata), 64'(o_icb_rsp_rdata));
      chk("rsp_err", 64'(hd ? m1_icb_rsp_err : m0_icb_rsp_err), 64'(o_icb_rsp_err));
    end
    pop = o_icb_rsp_valid && ers;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (hs) begin
      exp_q.push_back(1'(g)); last_m = g; lock_id = -1;
      grant_log.push_back(g);
      if (g == 0) acc0 = 1; else acc1 = 1;
    end else if (ecv) begin
      lock_id = g;
    end
    #1;
    if (acc0) m0_icb_cmd_valid = 1'b0;
    if (acc1) m1_icb_cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0; o_icb_rsp_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
    while (exp_q.size() > 0 && n < 20) begin
      o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = $urandom; o_icb_rsp_err = 1'($urandom_range(0, 1));
      cycle(); n++;
    end
    o_icb_rsp_valid = 1'b0;
    chk("drain_bound", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int c0, c1, n, base;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, n, base;
    rst = 1'b1;
    m0_icb_cmd_valid = 0; m0_icb_cmd_read = 0; m0_icb_cmd_addr = '0; m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0;
    m1_icb_cmd_valid = 0; m1_icb_cmd_read = 0; m1_icb_cmd_addr = '0; m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0;
    m0_icb_rsp_ready = 0; m1_icb_rsp_ready = 0;
    o_icb_cmd_ready = 0; o_icb_rsp_valid = 0; o_icb_rsp_err = 0; o_icb_rsp_rdata = '0;
    @(posedge clk); #1;
    do_reset();
    cycle();

    // T1: single m0 read, response goes to m0 only.
    set_m0(1'b1, 32'h8000_0000, 32'h0, 4'h0);
    o_icb_cmd_ready = 1'b1;
    #2 chk("t1_cmd_valid", 64'(o_icb_cmd_valid), 64'(1));
    chk("t1_addr", 64'(o_icb_cmd_addr), 64'h8000_0000);
    cycle();
    o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'h1234_5678; m0_icb_rsp_ready = 1'b1;
    #2 chk("t1_m0_rsp", 64'(m0_icb_rsp_valid), 64'(1));
    chk("t1_m1_rsp", 64'(m1_icb_rsp_valid), 64'(0));
    chk("t1_rdata", 64'(m0_icb_rsp_rdata), 64'h1234_5678);
    cycle();
    o_icb_rsp_valid = 1'b0;

    // T2: both masters streaming, grants alternate starting with m0.
    do_reset();
    grant_log.delete();
    c0 = 0; c1 = 0; n = 0;
    o_icb_cmd_ready = 1'b1; m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
    set_m0(1'b1, 32'h100, 32'h0, 4'hF); set_m1(1'b1, 32'h200, 32'h0, 4'hF);
    while ((c0 < 4 || c1 < 4) && n < 40) begin
      o_icb_rsp_valid = (exp_q.size() > 0); o_icb_rsp_rdata = $urandom;
      cycle(); n++;
      if (acc0) begin c0++; if (c0 < 4) set_m0(1'b1, 32'(32'h100 + c0 * 4), 32'h0, 4'hF); end
      if (acc1) begin c1++; if (c1 < 4) set_m1(1'b1, 32'(32'h200 + c1 * 4), 32'h0, 4'hF); end
    end
    chk("t2_cycles", 64'(n), 64'(8));
    for (int i = 0; i < 8; i++)
      chk("t2_order", 64'((i < grant_log.size()) ? grant_log[i] : 9), 64'(i % 2));
    drain();

    // T3: stalled m0 command keeps the grant while m1 joins.
    grant_log.delete();
    o_icb_cmd_ready = 1'b0;
    set_m0(1'b0, 32'h3000, 32'hDEAD_BEEF, 4'h3);
    cycle();
    set_m1(1'b1, 32'h4000, 32'h0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      #2 chk("t3_hold_addr", 64'(o_icb_cmd_addr), 64'h3000);
      cycle();
    end
    o_icb_cmd_ready = 1'b1;
    cycle(); cycle();
    chk("t3_order_len", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) begin
      chk("t3_first", 64'(grant_log[0]), 64'(0));
      chk("t3_second", 64'(grant_log[1]), 64'(1));
    end
    drain();

    // T4: third command blocked at full, even on the pop cycle.
    set_m0(1'b1, 32'h10, 32'h0, 4'h0); cycle();
    set_m1(1'b1, 32'h20, 32'h0, 4'h0); cycle();
    set_m0(1'b1, 32'h30, 32'h0, 4'h0);
    #2 chk("t4_blocked", 64'(o_icb_cmd_valid), 64'(0));
    cycle();
    o_icb_rsp_valid = 1'b1; m0_icb_rsp_ready = 1'b1;
    #2 chk("t4_blocked_on_pop", 64'(o_icb_cmd_valid), 64'(0));
    cycle();
    o_icb_rsp_valid = 1'b0;
    #2 chk("t4_accept", 64'(m0_icb_cmd_ready), 64'(1));
    cycle();
    drain();

    // T5: m1 then m0 outstanding; responses return in order, m1 stalls first.
    set_m1(1'b1, 32'h50, 32'h0, 4'h0); cycle();
    set_m0(1'b1, 32'h60, 32'h0, 4'h0); cycle();
    o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'hA; m1_icb_rsp_ready = 1'b0; m0_icb_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2 chk("t5_stall_ready", 64'(o_icb_rsp_ready), 64'(0));
      chk("t5_stall_m0", 64'(m0_icb_rsp_valid), 64'(0));
      cycle();
    end
    m1_icb_rsp_ready = 1'b1;
    #2 chk("t5_a_m1", 64'(m1_icb_rsp_valid), 64'(1));
    chk("t5_a_data", 64'(m1_icb_rsp_rdata), 64'hA);
    cycle();
    o_icb_rsp_rdata = 32'hB;
    #2 chk("t5_b_m0", 64'(m0_icb_rsp_valid), 64'(1));
    chk("t5_b_m1", 64'(m1_icb_rsp_valid), 64'(0));
    cycle();
    o_icb_rsp_valid = 1'b0;

    // T6: reset with two outstanding, then first contention goes to m0.
    set_m0(1'b1, 32'h70, 32'h0, 4'h0); cycle();
    set_m1(1'b1, 32'h80, 32'h0, 4'h0); cycle();
    do_reset();
    cycle();
    set_m0(1'b1, 32'h90, 32'h0, 4'h0); set_m1(1'b1, 32'hA0, 32'h0, 4'h0);
    #2 chk("t6_first_grant", 64'(m0_icb_cmd_ready), 64'(1));
    chk("t6_addr", 64'(o_icb_cmd_addr), 64'h90);
    cycle(); cycle();
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (!m0_icb_cmd_valid && $urandom_range(0, 2) == 0)
        set_m0(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!m1_icb_cmd_valid && $urandom_range(0, 2) == 0)
        set_m1(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      o_icb_cmd_ready  = 1'($urandom_range(0, 1));
      o_icb_rsp_valid  = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      o_icb_rsp_rdata  = $urandom;
      o_icb_rsp_err    = 1'($urandom_range(0, 1));
      m0_icb_rsp_ready = 1'($urandom_range(0, 1));
      m1_icb_rsp_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    o_icb_rsp_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
